// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register file writeback arbiter and its scoreboard.
package regfile_wb_arbiter_pkg;

    localparam logic REQ_EXU = 1'b0;
    localparam logic REQ_LSU = 1'b1;

    localparam int unsigned DEF_ADDR_WIDTH = 5;
    localparam int unsigned DEF_DATA_WIDTH = 32;

    typedef struct packed {
        logic                      valid;
        logic [DEF_ADDR_WIDTH-1:0] rd;
        logic [DEF_DATA_WIDTH-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: tracks in-flight writes and flags RAW/WAW hazards at issue.
module regfile_scoreboard
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       set_en,
    input  logic [ADDR_WIDTH-1:0]      set_idx,
    input  logic                       clr_en,
    input  logic [ADDR_WIDTH-1:0]      clr_idx,
    input  logic                       chk_valid,
    input  logic                       chk_wen,
    input  logic [ADDR_WIDTH-1:0]      chk_rd,
    input  logic [ADDR_WIDTH-1:0]      chk_rs1,
    input  logic [ADDR_WIDTH-1:0]      chk_rs2,
    output logic                       hazard,
    output logic [2**ADDR_WIDTH-1:0]   busy
);

    localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

    logic [NumRegs-1:0] busy_q, busy_d;

    // Set is applied after clear so a same-index collision leaves the bit set.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_idx] = 1'b0;
        end
        if (set_en) begin
            busy_d[set_idx] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        hazard = chk_valid &&
                 (busy_q[chk_rs1] || busy_q[chk_rs2] || (chk_wen && busy_q[chk_rd]));
    end

    assign busy = busy_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between EXU and LSU writebacks,
// with a busy scoreboard that stalls issue on hazards against in-flight writes.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     iss_valid,
    input  logic                     iss_wen,
    input  logic [ADDR_WIDTH-1:0]    iss_rd,
    input  logic [ADDR_WIDTH-1:0]    iss_rs1,
    input  logic [ADDR_WIDTH-1:0]    iss_rs2,
    output logic                     iss_stall,
    input  logic                     a_valid,
    input  logic [ADDR_WIDTH-1:0]    a_rd,
    input  logic [DATA_WIDTH-1:0]    a_data,
    output logic                     a_ready,
    input  logic                     b_valid,
    input  logic [ADDR_WIDTH-1:0]    b_rd,
    input  logic [DATA_WIDTH-1:0]    b_data,
    output logic                     b_ready,
    output logic                     rf_wen,
    output logic [ADDR_WIDTH-1:0]    rf_rd,
    output logic [DATA_WIDTH-1:0]    rf_data,
    output logic [2**ADDR_WIDTH-1:0] busy
);

    logic prio_q, prio_d;
    logic grant_a, grant_b;
    logic hazard;
    logic iss_set;

    always_comb begin
        grant_a = !rst && a_valid && (!b_valid || prio_q == REQ_EXU);
        grant_b = !rst && b_valid && (!a_valid || prio_q == REQ_LSU);
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    // Writes to x0 are acknowledged but never reach the register file.
    always_comb begin
        rf_rd   = grant_b ? b_rd : a_rd;
        rf_data = grant_b ? b_data : a_data;
        rf_wen  = (grant_a || grant_b) && (rf_rd != '0);
    end

    always_comb begin
        prio_d = prio_q;
        if (grant_a) begin
            prio_d = REQ_LSU;
        end else if (grant_b) begin
            prio_d = REQ_EXU;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= REQ_EXU;
        end else begin
            prio_q <= prio_d;
        end
    end

    assign iss_stall = rst || hazard;
    assign iss_set   = iss_valid && !iss_stall && iss_wen && (iss_rd != '0);

    regfile_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .set_en    (iss_set),
        .set_idx   (iss_rd),
        .clr_en    (grant_a || grant_b),
        .clr_idx   (rf_rd),
        .chk_valid (iss_valid),
        .chk_wen   (iss_wen),
        .chk_rd    (iss_rd),
        .chk_rs1   (iss_rs1),
        .chk_rs2   (iss_rs2),
        .hazard    (hazard),
        .busy      (busy)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios then randomized traffic
// against a behavioural model of the arbitration and scoreboard rules.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        iss_valid, iss_wen;
    logic [4:0]  iss_rd, iss_rs1, iss_rs2;
    logic        iss_stall;
    logic        a_valid, a_ready;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    logic        b_valid, b_ready;
    logic [4:0]  b_rd;
    logic [31:0] b_data;
    logic        rf_wen;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data;
    logic [31:0] busy;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Behavioural model state
    logic [31:0] m_busy;
    bit          m_prio_b;
    bit          e_a, e_b, e_wen, e_stall;
    logic [4:0]  e_rd;
    logic [31:0] e_data;

    // Register file built from the DUT's write port
    logic [31:0] tb_rf [32];

    regfile_wb_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_wen   (iss_wen),
        .iss_rd    (iss_rd),
        .iss_rs1   (iss_rs1),
        .iss_rs2   (iss_rs2),
        .iss_stall (iss_stall),
        .a_valid   (a_valid),
        .a_rd      (a_rd),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_rd      (b_rd),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .rf_wen    (rf_wen),
        .rf_rd     (rf_rd),
        .rf_data   (rf_data),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (rf_wen) tb_rf[rf_rd] <= rf_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Predict this cycle's outputs from the rules and compare.
    task automatic settle();
        #1;
        if (rst) begin
            e_a = 0; e_b = 0; e_wen = 0; e_stall = 1;
        end else begin
            e_a = a_valid && (!b_valid || !m_prio_b);
            e_b = b_valid && (!a_valid || m_prio_b);
            e_stall = iss_valid && (m_busy[iss_rs1] || m_busy[iss_rs2] ||
                                    (iss_wen && m_busy[iss_rd]));
        end
        e_rd   = e_a ? a_rd : b_rd;
        e_data = e_a ? a_data : b_data;
        e_wen  = (e_a || e_b) && (e_rd != 5'd0);
        chk("a_ready", {31'd0, a_ready}, {31'd0, e_a});
        chk("b_ready", {31'd0, b_ready}, {31'd0, e_b});
        chk("rf_wen", {31'd0, rf_wen}, {31'd0, e_wen});
        chk("iss_stall", {31'd0, iss_stall}, {31'd0, e_stall});
        chk("busy", busy, m_busy);
        if (e_wen) begin
            chk("rf_rd", {27'd0, rf_rd}, {27'd0, e_rd});
            chk("rf_data", rf_data, e_data);
        end
    endtask

    // Advance one clock edge and update the model.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_busy   = '0;
            m_prio_b = 0;
        end else begin
            if (e_a) m_busy[a_rd] = 1'b0;
            if (e_b) m_busy[b_rd] = 1'b0;
            if (iss_valid && !e_stall && iss_wen && iss_rd != 5'd0) m_busy[iss_rd] = 1'b1;
            if (e_a) m_prio_b = 1;
            else if (e_b) m_prio_b = 0;
        end
        #1;
    endtask

    logic [4:0]  exp_rd  [4];
    logic [31:0] exp_dat [4];

    initial begin
        m_busy = '0; m_prio_b = 0;
        rst = 1; iss_valid = 0; iss_wen = 0; iss_rd = 0; iss_rs1 = 0; iss_rs2 = 0;
        a_valid = 1; a_rd = 5'd3; a_data = 32'h11;
        b_valid = 1; b_rd = 5'd5; b_data = 32'h22;

        // Reset held for two cycles with both requesters valid
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("rst_a_ready", {31'd0, a_ready}, 32'd0);
            chk("rst_b_ready", {31'd0, b_ready}, 32'd0);
            chk("rst_rf_wen", {31'd0, rf_wen}, 32'd0);
            tick();
        end
        rst = 0;

        // Contention: A first after reset, then strict alternation
        exp_rd[0] = 5'd3;  exp_rd[1] = 5'd5;  exp_rd[2] = 5'd3;  exp_rd[3] = 5'd5;
        exp_dat[0] = 32'h11; exp_dat[1] = 32'h22; exp_dat[2] = 32'h11; exp_dat[3] = 32'h22;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("cont_a_ready", {31'd0, a_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("cont_b_ready", {31'd0, b_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
            chk("cont_rf_rd", {27'd0, rf_rd}, {27'd0, exp_rd[i]});
            chk("cont_rf_data", rf_data, exp_dat[i]);
            tick();
        end
        a_valid = 0; b_valid = 0;

        // RAW hazard on x7 resolved by an LSU writeback
        iss_valid = 1; iss_wen = 1; iss_rd = 5'd7;
        settle();
        chk("raw_issue_stall", {31'd0, iss_stall}, 32'd0);
        tick();
        iss_wen = 0; iss_rd = 0; iss_rs1 = 5'd7;
        settle();
        chk("raw_stall_1", {31'd0, iss_stall}, 32'd1);
        tick();
        b_valid = 1; b_rd = 5'd7; b_data = 32'hDEADBEEF;
        settle();
        chk("raw_stall_wb", {31'd0, iss_stall}, 32'd1);
        chk("raw_b_ready", {31'd0, b_ready}, 32'd1);
        tick();
        b_valid = 0;
        settle();
        chk("raw_stall_after", {31'd0, iss_stall}, 32'd0);
        chk("raw_rf_x7", tb_rf[7], 32'hDEADBEEF);
        tick();

        // WAW hazard on x9 resolved by an EXU writeback
        iss_rs1 = 0; iss_wen = 1; iss_rd = 5'd9;
        settle();
        tick();
        settle();
        chk("waw_stall", {31'd0, iss_stall}, 32'd1);
        tick();
        a_valid = 1; a_rd = 5'd9; a_data = 32'h99;
        settle();
        chk("waw_stall_wb", {31'd0, iss_stall}, 32'd1);
        chk("waw_a_ready", {31'd0, a_ready}, 32'd1);
        tick();
        a_valid = 0;
        settle();
        chk("waw_stall_after", {31'd0, iss_stall}, 32'd0);
        chk("waw_busy9_clr", {31'd0, busy[9]}, 32'd0);
        tick();
        iss_valid = 0;
        settle();
        chk("waw_busy9_set", {31'd0, busy[9]}, 32'd1);
        tick();

        // x0 never becomes busy and is never written
        iss_valid = 1; iss_wen = 1; iss_rd = 5'd0;
        settle();
        tick();
        iss_valid = 0;
        a_valid = 1; a_rd = 5'd0; a_data = 32'h55;
        settle();
        chk("x0_busy0", {31'd0, busy[0]}, 32'd0);
        chk("x0_a_ready", {31'd0, a_ready}, 32'd1);
        chk("x0_rf_wen", {31'd0, rf_wen}, 32'd0);
        tick();
        a_valid = 0;

        // Reset mid-operation drops pending busy bits
        iss_valid = 1; iss_wen = 1; iss_rd = 5'd1;
        settle(); tick();
        iss_rd = 5'd2;
        settle(); tick();
        iss_valid = 0;
        settle();
        chk("mid_busy12", {30'd0, busy[2:1]}, 32'd3);
        rst = 1;
        tick();
        rst = 0;
        iss_valid = 1; iss_wen = 0; iss_rs1 = 5'd1; iss_rs2 = 5'd0;
        settle();
        chk("mid_busy_zero", busy, 32'd0);
        chk("mid_no_stall", {31'd0, iss_stall}, 32'd0);
        tick();

        // Randomized traffic; requesters hold their request until accepted
        a_valid = 0; b_valid = 0;
        for (int i = 0; i < 400; i++) begin
            if (!a_valid && $urandom_range(0, 2) == 0) begin
                a_valid = 1; a_rd = 5'($urandom_range(0, 7)); a_data = $urandom;
            end
            if (!b_valid && $urandom_range(0, 2) == 0) begin
                b_valid = 1; b_rd = 5'($urandom_range(0, 7)); b_data = $urandom;
            end
            iss_valid = 1'($urandom_range(0, 1));
            iss_wen   = 1'($urandom_range(0, 1));
            iss_rd    = 5'($urandom_range(0, 7));
            iss_rs1   = 5'($urandom_range(0, 7));
            iss_rs2   = 5'($urandom_range(0, 7));
            rst       = ($urandom_range(0, 63) == 0);
            settle();
            tick();
            if (e_a) a_valid = 0;
            if (e_b) b_valid = 0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port controller for the core's single-write-port register file. It shares the one write port between two writeback requesters: EXU, which returns single-cycle results, and LSU, which returns load data a variable number of cycles later. Arbitration between them is round-robin. A per-register busy scoreboard stalls issue on RAW and WAW hazards against writes that are still in flight. It sits between the issue/writeback logic and the register file's `wen`/`rd`/`dataD` inputs.

## Interface
- `ADDR_WIDTH`, default 5: register index width; 2^ADDR_WIDTH registers.
- `DATA_WIDTH`, default 32: register data width.

- `clk` in 1: sole clock; everything updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `iss_valid` in 1: issue stage presents an instruction.
- `iss_wen` in 1: the instruction will write `iss_rd`.
- `iss_rd`, `iss_rs1`, `iss_rs2` in ADDR_WIDTH: register indices of the instruction.
- `iss_stall` out 1: the instruction must not issue this cycle.
- `a_valid` in 1, `a_rd` in ADDR_WIDTH, `a_data` in DATA_WIDTH, `a_ready` out 1: EXU writeback handshake.
- `b_valid` in 1, `b_rd` in ADDR_WIDTH, `b_data` in DATA_WIDTH, `b_ready` out 1: LSU writeback handshake.
- `rf_wen` out 1, `rf_rd` out ADDR_WIDTH, `rf_data` out DATA_WIDTH: drive the register file write port.
- `busy` out 2^ADDR_WIDTH: scoreboard state, bit i set means a write to register i is pending.

## Operation
- **Handshake:** a transfer occurs when `x_valid && x_ready`. A requester holds valid, rd and data stable until ready is asserted.
- **Arbitration:**
  - Only one requester valid: that requester is granted.
  - Both valid: the requester indicated by `prio` is granted and the other sees ready=0.
  - `prio` is a 1-bit register, reset value A. After any grant it points to the requester that was not granted.
- **Write port:** `rf_wen`, `rf_rd` and `rf_data` combinationally mirror the granted requester.
  - `rf_wen` = grant and rd≠0.
  - A write to x0 is still acknowledged (ready=1) but never drives `rf_wen`.
- **Issue check:** `iss_stall` = `iss_valid` && (`busy[iss_rs1]` || `busy[iss_rs2]` || (`iss_wen` && `busy[iss_rd]`)).
  - The check uses registered `busy` only; there is no bypass of a same-cycle writeback.
- **Scoreboard set:** an issue that is valid, not stalled, has `iss_wen=1` and rd≠0 sets `busy[iss_rd]` at the next edge.
- **Scoreboard clear:** a granted writeback clears `busy[rd]` at the next edge.
  - A set and a clear of the same index in one cycle cannot occur, because of the WAW stall. If it does occur, set wins.
- **Unexpected writeback:** a writeback to a register that is not busy is still written; the scoreboard is unchanged.
- **Register x0:** `busy[0]` is constantly 0.

## Timing
- **Reset values:** `busy`=0, `prio`=A.
- **While `rst`=1:** `a_ready`=`b_ready`=0, `rf_wen`=0, `iss_stall`=1.
- **Reset mid-operation:** pending busy bits are dropped. Requesters keep valid high and are accepted after reset is released, A first.
- **Write latency:** a grant in cycle N writes the register file at the N→N+1 edge.
- **Clear vs. data:** `busy[rd]` clears at that same edge, so an issue in cycle N+1 sees the cleared bit and reads the new data.
- **Issue with a same-cycle writeback:** an instruction whose operand is being written back in cycle N stalls in cycle N and issues in N+1. The stall is exactly one cycle.
- **Throughput:** one write per cycle. Under continuous contention the grants alternate A, B, A, B.
- **Datapaths:** ready and `rf_*` are combinational from valid and `prio`. No combinational path exists from `iss_*` to the `a_*`/`b_*` handshakes.

## Structure
- **Shared package:** requester index constants (`REQ_EXU`=0, `REQ_LSU`=1), the default ADDR_WIDTH/DATA_WIDTH, and a writeback request struct (valid, rd, data).
- **Sub-module:** `regfile_scoreboard` holds the busy vector with set/clear ports and the hazard compare.
- **Top level:** arbitration and the `prio` register stay in the top module.

## Test plan
- **Reset:** hold `rst` for 2 cycles with `a_valid`=`b_valid`=1.
  - During reset: ready=0 and `rf_wen`=0.
  - First cycle after reset: `a_ready`=1, `b_ready`=0.
  - Second cycle: `b_ready`=1.
- **Contention:** `a_valid` and `b_valid` held high for 4 cycles, rd=3/5, data 0x11/0x22.
  - `rf_rd` sequence 3,5,3,5; `rf_data` 0x11,0x22,0x11,0x22.
- **RAW hazard:** issue rd=7 with wen, then issue rs1=7.
  - `iss_stall`=1 until the LSU writes rd=7 with 0xDEADBEEF in cycle N.
  - Stall drops in N+1 and the register file holds 0xDEADBEEF.
- **WAW hazard:** with x9 busy, issue rd=9 → stall.
  - After the EXU writes x9, issue proceeds and `busy[9]` is set again the cycle after.
- **x0 handling:** issue rd=0 → `busy[0]` stays 0.
  - EXU write to rd=0 → `a_ready`=1, `rf_wen`=0.
- **Reset mid-operation:** set busy on x1, x2, then assert `rst`.
  - `busy`=0 after reset and a later issue with rs1=1 does not stall.
